pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter ADDR_W, default 32, width of the PC field.
REQ-002 Parameter DATA_W, default 32, width of the instruction field.
REQ-003 Parameter RESET_PC, default 32'h00000000, value of out_pc whenever out_valid=0.
REQ-004 Parameter NOP_INST, default 32'h00000000, value of out_inst whenever out_valid=0.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 flush  in  1  discard all held entries (branch or exception redirect).
REQ-008 in_valid  in  1  upstream (IF) entry present.
REQ-009 in_ready  out  1  stage accepts the entry this cycle.
REQ-010 in_pc  in  ADDR_W  upstream PC.
REQ-011 in_inst  in  DATA_W  upstream instruction.
REQ-012 out_valid  out  1  downstream (ID) entry present.
REQ-013 out_ready  in  1  downstream consumes the entry this cycle.
REQ-014 out_pc  out  ADDR_W  registered PC to ID.
REQ-015 out_inst  out  DATA_W  registered instruction to ID.
REQ-016 stall_cnt  out  16  performance counter of backpressure cycles.

Function
REQ-017 Transfers occur only on in_valid&&in_ready (accept) and out_valid&&out_ready (issue).
REQ-018 Entries SHALL leave in acceptance order; no loss, duplication or reordering.
REQ-019 Accept-to-out_valid latency SHALL be 1 cycle when the stage is empty.
REQ-020 out_pc/out_inst/out_valid SHALL be driven directly from flops, with no combinational path from inputs.
REQ-021 When an entry issues and no replacement is loaded, the data registers SHALL load RESET_PC/NOP_INST.
REQ-022 flush=1 SHALL, on the next edge: clear all valid bits; load RESET_PC/NOP_INST; discard the input accepted in the same cycle.
REQ-023 in_ready MAY be asserted during flush, but the entry is dropped.
REQ-024 in_pc/in_inst SHALL be ignored when in_valid=0.
REQ-025 stall_cnt SHALL increment each cycle with out_valid=1, out_ready=0 and flush=0.
REQ-026 stall_cnt SHALL saturate at 16'hFFFF.
REQ-027 stall_cnt SHALL be cleared only by reset.

Reset
REQ-028 With rst=0 at posedge clk, all outputs SHALL take these values on that edge: out_valid=0, out_pc=RESET_PC, out_inst=NOP_INST, stall_cnt=0, skid storage empty.
REQ-029 Reset SHALL take priority over flush and any transfer.
REQ-030 Reset mid-stream SHALL drop all held entries.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-032 Macro PIPE_SKID_EN. Without it: single entry; in_ready = ~out_valid | out_ready (combinational); full throughput with ready pass-through.
REQ-033 With PIPE_SKID_EN: a main entry plus one skid entry; in_ready SHALL be a flop equal to ~skid_valid, with no combinational out_ready->in_ready path.
REQ-034 Skid FSM states are EMPTY, BUSY (main valid) and FULL (main+skid valid):
  - EMPTY->BUSY on accept.
  - BUSY->FULL on accept without issue.
  - BUSY->EMPTY on issue without accept.
  - BUSY stays BUSY on simultaneous accept+issue (the input goes to main).
  - FULL->BUSY on issue: skid moves to main; in_ready=0 in FULL, so no accept.
  - flush goes to EMPTY from any state.

Structure
REQ-035 Shared package pipe_pkg SHALL hold the default ADDR_W/DATA_W/RESET_PC/NOP_INST constants, the skid state encoding, and the stall_cnt width.
REQ-036 The skid storage and FSM SHALL be a sub-module pipe_skid_buf, instantiated only under PIPE_SKID_EN.

Verification
REQ-037 Reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, out_pc=0, out_inst=0, stall_cnt=0; in_ready=1 in the cycle after release.
REQ-038 Streaming: out_ready=1, push PCs 0x0,0x4,0x8 with insts 0xA,0xB,0xC back-to-back -> each appears one cycle later in order; one issue per cycle.
REQ-039 Backpressure (skid): out_ready=0, push 0x10 then 0x14 -> state FULL, in_ready=0; raise out_ready -> 0x10 issues, then 0x14; no loss.
REQ-040 Flush: with FULL, assert flush and in_valid (pc 0x20) together -> next cycle out_valid=0, out_inst=NOP_INST; 0x20 never issues.
REQ-041 Counter: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and holds.
REQ-042 Build both with and without PIPE_SKID_EN -> random valid/ready scoreboard passes; in non-skid build, in_ready follows out_ready in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, skid FSM encoding and counter helper for the IF/ID stage register.
package pipe_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
    localparam int unsigned STALL_W      = 16;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Saturating increment for the backpressure counter.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + STALL_W'(1);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between IF (upstream) and ID (downstream) around the stage register.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [DATA_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_inst;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Main + skid entry buffer with a registered in_ready, so out_ready never reaches in_ready combinationally.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(DEF_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst
);

    skid_state_e       state;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_inst;
    logic              accept;
    logic              issue;

    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;

    // in_ready is low exactly while the skid entry is occupied (FULL).
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state     <= SKID_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pc    <= RESET_PC;
            out_inst  <= NOP_INST;
            skid_pc   <= RESET_PC;
            skid_inst <= NOP_INST;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        state     <= SKID_BUSY;
                        out_valid <= 1'b1;
                        out_pc    <= in_pc;
                        out_inst  <= in_inst;
                    end
                end
                SKID_BUSY: begin
                    if (accept && issue) begin
                        out_pc   <= in_pc;
                        out_inst <= in_inst;
                    end else if (accept) begin
                        state     <= SKID_FULL;
                        in_ready  <= 1'b0;
                        skid_pc   <= in_pc;
                        skid_inst <= in_inst;
                    end else if (issue) begin
                        state     <= SKID_EMPTY;
                        out_valid <= 1'b0;
                        out_pc    <= RESET_PC;
                        out_inst  <= NOP_INST;
                    end
                end
                SKID_FULL: begin
                    if (issue) begin
                        state     <= SKID_BUSY;
                        in_ready  <= 1'b1;
                        out_pc    <= skid_pc;
                        out_inst  <= skid_inst;
                        skid_pc   <= RESET_PC;
                        skid_inst <= NOP_INST;
                    end
                end
                default: begin
                    state     <= SKID_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_pc    <= RESET_PC;
                    out_inst  <= NOP_INST;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// IF/ID pipeline stage register with backpressure counter.
// Define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(DEF_NOP_INST)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_stage_reg_if.slave    bus,
    output logic [STALL_W-1:0] stall_cnt
);

`ifdef PIPE_SKID_EN
    pipe_skid_buf #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_pc     (bus.in_pc),
        .in_inst   (bus.in_inst),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_pc    (bus.out_pc),
        .out_inst  (bus.out_inst)
    );
`else
    logic accept;

    // Single entry: ready passes straight through from downstream.
    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            bus.out_valid <= 1'b0;
            bus.out_pc    <= RESET_PC;
            bus.out_inst  <= NOP_INST;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_pc    <= bus.in_pc;
            bus.out_inst  <= bus.in_inst;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_pc    <= RESET_PC;
            bus.out_inst  <= NOP_INST;
        end
    end
`endif

    // Counts cycles where ID holds off a valid entry; flush cycles are not stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (bus.out_valid && !bus.out_ready && !flush) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
